wb4_memtest: RTL and testbench

WB4_MEMTEST -- requirements
Module: wb4_memtest

---
 rtl/wb4_memtest_pkg.sv | 22 ++
 rtl/wb4_memtest_issue.sv | 74 +++++++
 rtl/wb4_memtest.sv | 172 +++++++++++++++++
 tb/tb_wb4_memtest.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb4_memtest_pkg.sv
// Shared types and helpers for the Wishbone B4 memory tester.
package wb4_memtest_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWr   = 2'd1,
        StRd   = 2'd2,
        StFin  = 2'd3
    } state_e;

    // Widest supported bus; patterns are computed at this width and truncated.
    localparam int unsigned MaxBits = 128;
    // Outstanding counter width covers MAXOUT up to 255.
    localparam int unsigned OutBits = 8;

    // Test pattern for word index idx: zero-extended index XOR seed.
    function automatic logic [MaxBits-1:0] pattern(input logic [MaxBits-1:0] idx,
                                                   input logic [MaxBits-1:0] seed);
        return idx ^ seed;
    endfunction

endpackage

// File: rtl/wb4_memtest_issue.sv
// Request issue engine: word index, ack index and outstanding-request tracking.
// Cleared at the start of each phase and reused for both write and read passes.
module wb4_memtest_issue
    import wb4_memtest_pkg::*;
#(
    parameter int unsigned CNTBITSZ = 16,
    parameter int unsigned MAXOUT   = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clear,
    input  logic                active,
    input  logic [CNTBITSZ-1:0] count,
    input  logic                stall,
    input  logic                ack,
    output logic                stb,
    output logic [CNTBITSZ-1:0] issued,
    output logic [CNTBITSZ-1:0] acked,
    output logic                ack_valid,
    output logic                last_ack
);

    logic [CNTBITSZ-1:0] issued_q, issued_d;
    logic [CNTBITSZ-1:0] acked_q, acked_d;
    logic [OutBits-1:0]  outstanding_q, outstanding_d;
    logic                accept;

    // Strobe/accept decode and counter next-state.
    always_comb begin
        stb       = active && (issued_q < count) && (outstanding_q < OutBits'(MAXOUT));
        accept    = stb && !stall;
        // Acks with nothing in flight (or outside a cycle) are stray and dropped.
        ack_valid = active && ack && (outstanding_q != '0);
        last_ack  = ack_valid && (acked_q == count - CNTBITSZ'(1));

        issued_d      = issued_q;
        acked_d       = acked_q;
        outstanding_d = outstanding_q;
        if (clear) begin
            issued_d      = '0;
            acked_d       = '0;
            outstanding_d = '0;
        end else begin
            if (accept) begin
                issued_d = issued_q + CNTBITSZ'(1);
            end
            if (ack_valid) begin
                acked_d = acked_q + CNTBITSZ'(1);
            end
            case ({accept, ack_valid})
                2'b10:   outstanding_d = outstanding_q + OutBits'(1);
                2'b01:   outstanding_d = outstanding_q - OutBits'(1);
                default: outstanding_d = outstanding_q;
            endcase
        end
    end

    // Counter state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            issued_q      <= '0;
            acked_q       <= '0;
            outstanding_q <= '0;
        end else begin
            issued_q      <= issued_d;
            acked_q       <= acked_d;
            outstanding_q <= outstanding_d;
        end
    end

    assign issued = issued_q;
    assign acked  = acked_q;

endmodule

// File: rtl/wb4_memtest.sv
// Wishbone B4 pipelined memory tester: writes count pattern words, reads them
// back in issue order and reports mismatch count and first failing address.
module wb4_memtest
    import wb4_memtest_pkg::*;
#(
    parameter int unsigned ARCHBITSZ = 32,
    parameter int unsigned CNTBITSZ  = 16,
    parameter int unsigned MAXOUT    = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [ARCHBITSZ-1:0]   base_i,
    input  logic [CNTBITSZ-1:0]    count_i,
    input  logic [ARCHBITSZ-1:0]   seed_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   pass_o,
    output logic [CNTBITSZ-1:0]    errcnt_o,
    output logic [ARCHBITSZ-1:0]   firsterr_o,
    output logic                   wb4_cyc_o,
    output logic                   wb4_stb_o,
    output logic                   wb4_we_o,
    output logic [ARCHBITSZ-1:0]   wb4_addr_o,
    output logic [ARCHBITSZ-1:0]   wb4_data_o,
    output logic [ARCHBITSZ/8-1:0] wb4_sel_o,
    input  logic                   wb4_stall_i,
    input  logic                   wb4_ack_i,
    input  logic [ARCHBITSZ-1:0]   wb4_data_i
);

    localparam int unsigned SelBits   = ARCHBITSZ / 8;
    localparam int unsigned AlignBits = $clog2(SelBits);
    localparam logic [ARCHBITSZ-1:0] AlignMask = ~ARCHBITSZ'(SelBits - 1);

    state_e               state_q, state_d;
    logic                 run_q, run_d;
    logic                 clear, start_ok, mismatch;
    logic [ARCHBITSZ-1:0] base_q, seed_q, firsterr_q;
    logic [CNTBITSZ-1:0]  count_q, errcnt_q;
    logic                 pass_q;
    logic                 stb, ack_valid, last_ack;
    logic [CNTBITSZ-1:0]  issued, acked;
    logic [ARCHBITSZ-1:0] wr_addr, rd_addr, wr_pat, rd_pat;

    wb4_memtest_issue #(
        .CNTBITSZ (CNTBITSZ),
        .MAXOUT   (MAXOUT)
    ) u_issue (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear     (clear),
        .active    (run_q),
        .count     (count_q),
        .stall     (wb4_stall_i),
        .ack       (wb4_ack_i),
        .stb       (stb),
        .issued    (issued),
        .acked     (acked),
        .ack_valid (ack_valid),
        .last_ack  (last_ack)
    );

    // Phase sequencing; run_q is the bus cycle and drops for one cycle between phases.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        clear    = 1'b0;
        start_ok = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    clear    = 1'b1;
                    if (count_i == '0) begin
                        state_d = StFin;
                    end else begin
                        state_d = StWr;
                        run_d   = 1'b1;
                    end
                end
            end
            StWr: begin
                if (last_ack) begin
                    state_d = StRd;
                    run_d   = 1'b0;
                end
            end
            StRd: begin
                if (!run_q) begin
                    // Idle gap cycle: rearm the issue engine for the read pass.
                    clear = 1'b1;
                    run_d = 1'b1;
                end else if (last_ack) begin
                    state_d = StFin;
                    run_d   = 1'b0;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                run_d   = 1'b0;
            end
        endcase
    end

    // Addresses, patterns and bus outputs.
    always_comb begin
        wr_addr  = base_q + (ARCHBITSZ'(issued) << AlignBits);
        rd_addr  = base_q + (ARCHBITSZ'(acked) << AlignBits);
        wr_pat   = ARCHBITSZ'(pattern(MaxBits'(issued), MaxBits'(seed_q)));
        rd_pat   = ARCHBITSZ'(pattern(MaxBits'(acked), MaxBits'(seed_q)));
        mismatch = (state_q == StRd) && ack_valid && (wb4_data_i != rd_pat);

        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StFin);
        pass_o     = pass_q;
        errcnt_o   = errcnt_q;
        firsterr_o = firsterr_q;
        wb4_cyc_o  = run_q;
        wb4_stb_o  = stb;
        wb4_we_o   = run_q && (state_q == StWr);
        wb4_sel_o  = run_q ? '1 : '0;
        wb4_addr_o = run_q ? wr_addr : '0;
        wb4_data_o = wb4_we_o ? wr_pat : '0;
    end

    // FSM state and bus-cycle register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
        end
    end

    // Captured test parameters and result registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            base_q     <= '0;
            count_q    <= '0;
            seed_q     <= '0;
            errcnt_q   <= '0;
            firsterr_q <= '0;
            pass_q     <= 1'b0;
        end else if (start_ok) begin
            base_q     <= base_i & AlignMask;
            count_q    <= count_i;
            seed_q     <= seed_i;
            errcnt_q   <= '0;
            firsterr_q <= '0;
            pass_q     <= 1'b0;
        end else begin
            if (mismatch) begin
                if (errcnt_q != '1) begin
                    errcnt_q <= errcnt_q + CNTBITSZ'(1);
                end
                if (errcnt_q == '0) begin
                    firsterr_q <= rd_addr;
                end
            end
            if (state_q == StFin) begin
                pass_q <= (errcnt_q == '0);
            end
        end
    end

endmodule

// File: tb/tb_wb4_memtest.sv
// Directed bench for wb4_memtest with an in-bench pipelined Wishbone memory.
module tb_wb4_memtest;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [31:0] base_i;
    logic [15:0] count_i;
    logic [31:0] seed_i;
    logic        busy_o, done_o, pass_o;
    logic [15:0] errcnt_o;
    logic [31:0] firsterr_o;
    logic        wb4_cyc_o, wb4_stb_o, wb4_we_o;
    logic [31:0] wb4_addr_o, wb4_data_o;
    logic [3:0]  wb4_sel_o;
    logic        wb4_stall_i, wb4_ack_i;
    logic [31:0] wb4_data_i;

    always #5 clk = ~clk;

    wb4_memtest u_dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .base_i      (base_i),
        .count_i     (count_i),
        .seed_i      (seed_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .pass_o      (pass_o),
        .errcnt_o    (errcnt_o),
        .firsterr_o  (firsterr_o),
        .wb4_cyc_o   (wb4_cyc_o),
        .wb4_stb_o   (wb4_stb_o),
        .wb4_we_o    (wb4_we_o),
        .wb4_addr_o  (wb4_addr_o),
        .wb4_data_o  (wb4_data_o),
        .wb4_sel_o   (wb4_sel_o),
        .wb4_stall_i (wb4_stall_i),
        .wb4_ack_i   (wb4_ack_i),
        .wb4_data_i  (wb4_data_i)
    );

    // Responder knobs, driven from the stimulus block only.
    int unsigned delay = 0;
    int unsigned lat   = 1;
    bit          corrupt_en = 1'b0;
    bit [31:0]   corrupt_a, corrupt_b;
    bit          inj_ack = 1'b0;

    // Responder state: 64-word memory, stall counter, ack pipeline.
    bit [31:0]   mem [64];
    int unsigned stall_cnt;
    bit          ack_pipe [4];
    bit [31:0]   data_pipe [4];

    assign wb4_stall_i = wb4_stb_o && (stall_cnt < delay);
    assign wb4_ack_i   = ack_pipe[0] | inj_ack;
    assign wb4_data_i  = data_pipe[0];

    // Bus values sampled mid-cycle, acted on at the next rising edge.
    bit        s_acc, s_we, s_stalled, s_ack;
    bit [31:0] s_addr, s_data;

    // Monitor counters.
    int        n_wr, n_rd, n_done, n_cyc_rise, n_unstable, n_stall, n_ack_raw, n_log;
    int        n_rd_done, n_rdack;
    bit [31:0] addr_log [256];
    bit        prev_stalled, prev_cyc;
    bit [31:0] p_addr, p_data;
    bit        p_we;
    bit [3:0]  p_sel;

    // Negative-edge sampler and protocol monitor.
    always @(negedge clk) begin
        s_acc     = wb4_cyc_o && wb4_stb_o && !wb4_stall_i;
        s_stalled = wb4_stb_o && wb4_stall_i;
        s_we      = wb4_we_o;
        s_addr    = wb4_addr_o;
        s_data    = wb4_data_o;
        s_ack     = wb4_ack_i && wb4_cyc_o;
        if (s_acc) begin
            if (s_we) begin
                n_wr++;
                if (n_log < 256) begin
                    addr_log[n_log] = s_addr;
                    n_log++;
                end
            end else begin
                n_rd++;
            end
        end
        if (prev_stalled && (wb4_addr_o != p_addr || wb4_data_o != p_data ||
                             wb4_we_o != p_we || wb4_sel_o != p_sel)) begin
            n_unstable++;
        end
        prev_stalled = s_stalled;
        p_addr = wb4_addr_o;
        p_data = wb4_data_o;
        p_we   = wb4_we_o;
        p_sel  = wb4_sel_o;
        if (s_stalled) n_stall++;
        if (wb4_cyc_o && !prev_cyc) n_cyc_rise++;
        prev_cyc = wb4_cyc_o;
        if (done_o) n_done++;
        if (wb4_ack_i) n_ack_raw++;
    end

    // Memory responder.
    always @(posedge clk) begin
        bit [31:0] rdata;
        for (int i = 0; i < 3; i++) begin
            ack_pipe[i]  <= ack_pipe[i+1];
            data_pipe[i] <= data_pipe[i+1];
        end
        ack_pipe[3]  <= 1'b0;
        data_pipe[3] <= '0;
        if (s_acc) begin
            stall_cnt <= 0;
            rdata = '0;
            if (s_we) begin
                mem[s_addr[7:2]] = s_data;
            end else begin
                rdata = mem[s_addr[7:2]];
                if (corrupt_en && (s_addr == corrupt_a || s_addr == corrupt_b)) rdata ^= 32'h1;
                n_rd_done++;
            end
            ack_pipe[lat-1]  <= 1'b1;
            data_pipe[lat-1] <= rdata;
        end else if (s_stalled) begin
            stall_cnt <= stall_cnt + 1;
        end
        if (s_ack && !s_we) n_rdack++;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-run deltas.
    int d_wr, d_rd, d_done, d_cyc, d_unstable, d_stall, l0;

    task automatic run(input logic [31:0] b, input logic [15:0] c, input logic [31:0] s,
                       input bit poke, input string tag);
        int w0, r0, dn0, c0, u0, st0;
        bit seen;
        w0 = n_wr; r0 = n_rd; dn0 = n_done; c0 = n_cyc_rise; u0 = n_unstable; st0 = n_stall;
        l0 = n_log;
        seen = 1'b0;
        @(negedge clk);
        base_i = b; count_i = c; seed_i = s; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check({tag, "_busy"}, busy_o, 1);
        for (int k = 0; k < 4000; k++) begin
            if (done_o) begin
                seen = 1'b1;
                break;
            end
            // A second start while busy must be ignored.
            start_i = poke && (k == 5);
            if (poke && k == 5) count_i = 16'd3;
            @(negedge clk);
        end
        start_i = 1'b0;
        check({tag, "_done_seen"}, seen, 1);
        repeat (3) @(negedge clk);
        d_wr = n_wr - w0; d_rd = n_rd - r0; d_done = n_done - dn0;
        d_cyc = n_cyc_rise - c0; d_unstable = n_unstable - u0; d_stall = n_stall - st0;
    endtask

    initial begin
        int d0, c0, a0;
        bit seen;
        rst_i = 1'b1; start_i = 1'b0; base_i = '0; count_i = '0; seed_i = '0;
        #2 rst_i = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state.
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_pass", pass_o, 0);
        check("rst_errcnt", errcnt_o, 0);
        check("rst_firsterr", firsterr_o, 0);
        check("rst_cyc", wb4_cyc_o, 0);
        check("rst_stb", wb4_stb_o, 0);
        check("rst_we", wb4_we_o, 0);
        check("rst_addr", wb4_addr_o, 0);
        check("rst_data", wb4_data_o, 0);
        check("rst_sel", wb4_sel_o, 0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait memory, one-cycle ack; stray start while busy.
        delay = 0; lat = 1;
        run(32'h100, 16'd16, 32'hA5A5A5A5, 1'b1, "a");
        check("a_pass", pass_o, 1);
        check("a_errcnt", errcnt_o, 0);
        check("a_firsterr", firsterr_o, 0);
        check("a_writes", d_wr, 16);
        check("a_reads", d_rd, 16);
        check("a_done_pulse", d_done, 1);
        check("a_cyc_phases", d_cyc, 2);
        check("a_mem5", mem[5], 32'hA5A5A5A0);
        check("a_mem15", mem[15], 32'hA5A5A5AA);
        check("a_idle", busy_o, 0);

        // Two stall cycles per request, two-cycle ack latency.
        delay = 2; lat = 2;
        run(32'h100, 16'd16, 32'h5A5A0000, 1'b0, "b");
        check("b_pass", pass_o, 1);
        check("b_errcnt", errcnt_o, 0);
        check("b_writes", d_wr, 16);
        check("b_reads", d_rd, 16);
        check("b_stalled", d_stall != 0, 1);
        check("b_stable", d_unstable, 0);
        check("b_mem3", mem[3], 32'h5A5A0003);

        // Corrupt read data of words 3 and 7.
        delay = 0; lat = 2;
        corrupt_en = 1'b1; corrupt_a = 32'h10C; corrupt_b = 32'h11C;
        run(32'h100, 16'd16, 32'hA5A5A5A5, 1'b0, "c");
        corrupt_en = 1'b0;
        check("c_errcnt", errcnt_o, 2);
        check("c_firsterr", firsterr_o, 32'h10C);
        check("c_pass", pass_o, 0);
        check("c_done_pulse", d_done, 1);

        // Zero-length test: straight to FIN, no bus cycle.
        d0 = n_done; c0 = n_cyc_rise;
        @(negedge clk);
        count_i = '0; base_i = 32'h80; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("z_done_fin", done_o, 1);
        check("z_cyc", wb4_cyc_o, 0);
        @(negedge clk);
        check("z_done_low", done_o, 0);
        check("z_pass", pass_o, 1);
        check("z_errcnt", errcnt_o, 0);
        check("z_busy", busy_o, 0);
        repeat (2) @(negedge clk);
        check("z_no_cyc", n_cyc_rise - c0, 0);
        check("z_done_pulse", n_done - d0, 1);

        // Address wrap at the top of the address space.
        delay = 0; lat = 1;
        run(32'hFFFF_FFF8, 16'd4, 32'h0, 1'b0, "w");
        check("w_addr0", addr_log[(l0 + 0) % 256], 32'hFFFF_FFF8);
        check("w_addr1", addr_log[(l0 + 1) % 256], 32'hFFFF_FFFC);
        check("w_addr2", addr_log[(l0 + 2) % 256], 32'h0000_0000);
        check("w_addr3", addr_log[(l0 + 3) % 256], 32'h0000_0004);
        check("w_pass", pass_o, 1);

        // Reset in the read phase with two reads in flight.
        delay = 0; lat = 3;
        d0 = n_done;
        @(negedge clk);
        base_i = 32'h200; count_i = 16'd16; seed_i = 32'h33; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 500; k++) begin
            if (wb4_cyc_o && !wb4_we_o && (n_rd_done - n_rdack) == 2) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("r_reach_rd", seen, 1);
        a0 = n_ack_raw;
        rst_i = 1'b0;
        #1;
        check("r_cyc", wb4_cyc_o, 0);
        check("r_stb", wb4_stb_o, 0);
        check("r_busy", busy_o, 0);
        #1 rst_i = 1'b1;
        repeat (6) @(negedge clk);
        check("r_late_acks", n_ack_raw - a0 != 0, 1);
        check("r_idle", busy_o, 0);
        check("r_cyc_after", wb4_cyc_o, 0);
        check("r_errcnt", errcnt_o, 0);
        check("r_no_done", n_done - d0, 0);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        check("r_stray_idle", busy_o, 0);

        // Tester recovers cleanly after the interrupted run.
        lat = 1;
        run(32'h40, 16'd2, 32'h77, 1'b0, "p");
        check("p_pass", pass_o, 1);
        check("p_writes", d_wr, 2);
        check("p_reads", d_rd, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
